// File: rtl/systolic_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | systolic_drain: deskews the array's bottom-row partial sums into rows,   |
// | buffers them in a FIFO and presents them on a valid/ready port.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module systolic_drain #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ROWS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arr_valid,
    input  logic [N*DATA_W-1:0]     arr_out,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [N*DATA_W-1:0]     m_data,
    output logic                    m_last,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [LW-1:0] c_FULL     = LW'(DEPTH);
    localparam logic [RW-1:0] c_LAST_ROW = RW'(ROWS - 1);

    logic [N*DATA_W-1:0] w_row;
    logic                w_stb;

    // Column j trails column 0 by j cycles, so it needs N-1-j stages to line up.
    for (genvar j = 0; j < N; j++) begin : g_col
        localparam int D = N - 1 - j;
        if (D == 0) begin : g_pass
            assign w_row[j*DATA_W +: DATA_W] = arr_out[j*DATA_W +: DATA_W];
        end else begin : g_dly
            logic [DATA_W-1:0] dly_q [D];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) dly_q[k] <= '0;
                end else begin
                    dly_q[0] <= arr_out[j*DATA_W +: DATA_W];
                    for (int k = 1; k < D; k++) dly_q[k] <= dly_q[k-1];
                end
            end
            assign w_row[j*DATA_W +: DATA_W] = dly_q[D-1];
        end
    end

    if (N > 1) begin : g_vld
        logic [N-2:0] vld_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= arr_valid;
                for (int k = 1; k < N - 1; k++) vld_q[k] <= vld_q[k-1];
            end
        end
        assign w_stb = vld_q[N-2];
    end else begin : g_novld
        assign w_stb = arr_valid;
    end

    logic [N*DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]       wr_q, rd_q;
    logic [LW-1:0]       cnt_q, cnt_d;
    logic [RW-1:0]       row_q;
    logic                ovf_q;
    logic                w_full, w_pop, w_push, w_drop;

    assign w_full = (cnt_q == c_FULL);
    assign w_pop  = (cnt_q != '0) && m_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign w_push = w_stb && (!w_full || w_pop);
    assign w_drop = w_stb && w_full && !w_pop;

    always_comb begin
        cnt_d = cnt_q;
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + LW'(1);
            2'b01:   cnt_d = cnt_q - LW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            row_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (w_push) wr_q <= wr_q + PW'(1);
            if (w_pop) begin
                rd_q  <= rd_q + PW'(1);
                row_q <= (row_q == c_LAST_ROW) ? '0 : row_q + RW'(1);
            end
            if (w_drop) ovf_q <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_q] <= w_row;
    end

    assign m_valid  = (cnt_q != '0);
    assign m_data   = m_valid ? mem_q[rd_q] : '0;
    assign m_last   = m_valid && (row_q == c_LAST_ROW);
    assign overflow = ovf_q;
    assign level    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_systolic_drain: directed scoreboard bench for systolic_drain.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_systolic_drain;

    localparam int N      = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int ROWS   = 4;
    localparam int W      = N * DATA_W;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   arr_valid = 1'b0;
    logic [W-1:0]           arr_out = '0;
    logic                   m_valid;
    logic                   m_ready = 1'b0;
    logic [W-1:0]           m_data;
    logic                   m_last;
    logic                   overflow;
    logic [$clog2(DEPTH):0] level;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q_data [$];
    bit           q_last [$];
    int           exp_cnt = 0;
    logic [W-1:0] sr [N];

    systolic_drain #(.N(N), .DATA_W(DATA_W), .DEPTH(DEPTH), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .arr_valid(arr_valid), .arr_out(arr_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int base);
        logic [W-1:0] r;
        for (int j = 0; j < N; j++) r[j*DATA_W +: DATA_W] = DATA_W'(base + j);
        return r;
    endfunction

    // Each cycle column j carries the row issued j cycles earlier.
    task automatic step(input bit v, input logic [W-1:0] row, input bit keep);
        for (int k = N - 1; k > 0; k--) sr[k] = sr[k-1];
        sr[0] = v ? row : '0;
        arr_valid = v;
        for (int j = 0; j < N; j++) arr_out[j*DATA_W +: DATA_W] = sr[j][j*DATA_W +: DATA_W];
        if (v && keep) begin
            q_data.push_back(row);
            q_last.push_back((exp_cnt % ROWS) == ROWS - 1);
            exp_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset(input string nm);
        arr_valid = 1'b0;
        arr_out   = '0;
        m_ready   = 1'b0;
        rst       = 1'b1;
        #1;
        check({nm, "_valid"},  128'(m_valid),  128'(0));
        check({nm, "_level"},  128'(level),    128'(0));
        check({nm, "_ovf"},    128'(overflow), 128'(0));
        check({nm, "_last"},   128'(m_last),   128'(0));
        check({nm, "_data"},   128'(m_data),   128'(0));
        q_data.delete();
        q_last.delete();
        exp_cnt = 0;
        for (int k = 0; k < N; k++) sr[k] = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (q_data.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_row: got %0h expected none", m_data);
            end else begin
                check("row_data", 128'(m_data), 128'(q_data.pop_front()));
                check("row_last", 128'(m_last), 128'(q_last.pop_front()));
            end
        end
    end

    initial begin
        for (int k = 0; k < N; k++) sr[k] = '0;
        @(posedge clk); #1;
        do_reset("rst0");

        // Single row: latency and level
        step(1'b1, mk(10), 1'b1);
        for (int k = 1; k <= N; k++) begin
            check("single_valid", 128'(m_valid), 128'(k == N));
            if (k < N) idle(1);
        end
        check("single_level", 128'(level), 128'(1));
        check("single_data", 128'(m_data), 128'(mk(10)));
        m_ready = 1'b1;
        idle(1);
        check("single_level0", 128'(level), 128'(0));
        check("single_empty", 128'(m_valid), 128'(0));

        // Burst of 4 with m_ready high
        do_reset("rst1");
        m_ready = 1'b1;
        for (int r = 0; r < 4; r++) step(1'b1, mk(16 * r), 1'b1);
        idle(6);
        check("burst_level", 128'(level), 128'(0));

        // Backpressure and overflow
        do_reset("rst2");
        for (int r = 0; r < 9; r++) step(1'b1, mk(256 + 16 * r), r < 8);
        idle(2);
        check("bp_level8", 128'(level), 128'(8));
        check("bp_ovf0", 128'(overflow), 128'(0));
        idle(1);
        check("bp_level_hold", 128'(level), 128'(8));
        check("bp_ovf1", 128'(overflow), 128'(1));
        m_ready = 1'b1;
        idle(10);
        check("bp_drained", 128'(level), 128'(0));
        check("bp_ovf_sticky", 128'(overflow), 128'(1));

        // Full with simultaneous push and pop
        do_reset("rst3");
        for (int r = 0; r < 9; r++) step(1'b1, mk(512 + 16 * r), 1'b1);
        idle(2);
        check("fp_level8", 128'(level), 128'(8));
        m_ready = 1'b1;
        idle(1);
        check("fp_level_same", 128'(level), 128'(8));
        check("fp_ovf0", 128'(overflow), 128'(0));
        idle(10);
        check("fp_drained", 128'(level), 128'(0));
        check("fp_ovf_end", 128'(overflow), 128'(0));

        // Reset mid-operation: 3 rows buffered, 1 in the deskew
        do_reset("rst4");
        for (int r = 0; r < 4; r++) step(1'b1, mk(1024 + 16 * r), 1'b0);
        idle(2);
        check("mid_level3", 128'(level), 128'(3));
        do_reset("rst_mid");
        idle(3);
        check("mid_discard", 128'(level), 128'(0));
        m_ready = 1'b1;
        step(1'b1, mk(2048), 1'b1);
        for (int k = 1; k <= N; k++) begin
            check("mid_valid", 128'(m_valid), 128'(k == N));
            check("mid_level", 128'(level), 128'(k == N));
            idle(1);
        end
        idle(3);
        check("mid_final_level", 128'(level), 128'(0));
        check("sb_empty", 128'(q_data.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_drain.md
# systolic_drain

Output-side companion to the 4x4 systolic array: captures the diagonally skewed partial-sum stream leaving the bottom row and realigns it into whole result rows. Buffers those rows in a small FIFO and hands them to downstream logic over a valid/ready handshake. Marks the last row of each tile and flags any row lost to overflow. The array cannot stall, so this block absorbs all backpressure.

## Interface
Parameters:
- N, 4: array dimension (columns per result row).
- DATA_W, 32: width of one partial sum.
- DEPTH, 8: FIFO depth in rows (power of two, at least 2).
- ROWS, 4: result rows per tile (sets m_last spacing).

Ports:
- clk, in, 1: sole clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- arr_valid, in, 1: column 0 of arr_out carries a valid sum this cycle.
- arr_out, in, N*DATA_W: bottom-row outputs of the array; column j is bits [j*DATA_W +: DATA_W].
- m_valid, out, 1: a result row is available.
- m_ready, in, 1: downstream accepts the row.
- m_data, out, N*DATA_W: aligned row; same column packing as arr_out.
- m_last, out, 1: the presented row is row ROWS-1 of its tile.
- overflow, out, 1: sticky; a row was dropped because the FIFO was full.
- level, out, clog2(DEPTH)+1: current FIFO occupancy.

## Operation
Skew model:
- Column j of arr_out belongs to the same result row as column 0 of j cycles earlier.
- The array controller raises arr_valid in the cycle column 0 of a row appears.

Deskew:
- Column j passes through a (N-1-j)-stage register delay; column N-1 is not delayed.
- arr_valid passes through an (N-1)-stage delay to form the push strobe.
- In the push cycle, all N columns of one row are aligned.

FIFO:
- DEPTH entries, with write pointer, read pointer and occupancy counter.
- Push: push strobe is high and the FIFO is not full, or a pop happens in the same cycle.
- Pop: m_valid and m_ready are both high.
- Full with push strobe and no pop: the row is dropped, overflow sets and stays set until rst, and FIFO contents are unchanged.
- Pointers wrap modulo DEPTH.

Output:
- m_data shows the head entry; it is held stable while m_valid is high and m_ready is low.
- Row counter: 0..ROWS-1, advances on each pop, wraps to 0 after ROWS-1.
- m_last = m_valid and (row counter == ROWS-1).

Arithmetic:
- Data passes through unmodified; the block performs no arithmetic on sums.

## Timing
Reset values (applied immediately on rst high, independent of clk):
- m_valid 0, m_last 0, overflow 0, level 0, m_data 0.
- Pointers, row counter, and all delay registers 0.

Latency:
- arr_valid in cycle t puts the aligned row in the FIFO at the edge ending cycle t+N-1.
- With the FIFO previously empty, m_valid is high from cycle t+N (4 cycles for N=4).
- There is no bypass path.

Throughput:
- One row per cycle sustained while m_ready is held high.
- arr_valid may be high on consecutive cycles.

Simultaneous push and pop:
- When full: both happen, level is unchanged, no overflow.
- When holding one entry: the head is popped and the new row becomes the head next cycle, so m_valid stays high.

Backpressure and level:
- m_ready low with the FIFO empty has no effect.
- level updates on the same edge as the push or pop that changes it.

Reset mid-operation:
- Rows in flight in the delay lines and in the FIFO are discarded.
- The first arr_valid after rst deasserts behaves as from a cold start.

## Test plan
- Single row: arr_valid at cycle 0; column j = 10+j presented at cycle j -> m_valid at cycle 4 with m_data columns {10,11,12,13}; level 1 to 0 after the handshake.
- Burst of 4 rows with m_ready high: arr_valid cycles 0-3, row r column j = 16r+j -> rows appear on cycles 4-7 in order; m_last high only on row 3.
- Backpressure: m_ready low, 9 consecutive rows with DEPTH=8 -> level reaches 8, overflow sets on the 9th push; m_ready then high -> rows 0-7 out in order, row 8 absent, overflow still 1.
- Full plus simultaneous pop: FIFO full, m_ready high while a push lands -> level stays 8, overflow stays 0, output order preserved.
- m_last wrap: 8 rows with ROWS=4 -> m_last on the 4th and 8th pops only.
- Reset mid-operation: rst pulsed while 3 rows are in the FIFO and 1 is in the deskew -> m_valid 0 and level 0 immediately; a later single row emerges exactly 4 cycles after its arr_valid and is the only row out.
